decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//   Parametrised RV32I decode stage: owns the IF/ID pipeline register (stall/flush/valid),
//   the register file with optional W->D write-through bypass, and control/immediate decode.
//   Adds illegal-opcode detection, a sticky error flag and a decoded-instruction counter.
//   Sits between fetch and the ID/EX register; the hazard unit drives StallD/FlushD.
// PARAMETERS
//   DATA_WIDTH              32  datapath and register width
//   REG_FILE_ADDRESS_WIDTH  5   register index width; NUM_REGS = 2**REG_FILE_ADDRESS_WIDTH
//   CNT_WIDTH               16  width of DecodeCount (saturating)
// PORTS
//   clk             in   1      clock, all state updates on posedge
//   rst             in   1      synchronous, active-high reset
//   StallD          in   1      hold IF/ID register
//   FlushD          in   1      bubble IF/ID register
//   instrF          in   DW     fetched instruction
//   PCF, PCPlus4F   in   DW     fetch PC / PC+4
//   ResultW         in   DW     writeback data
//   RdW             in   RAW    writeback index
//   RegWriteW       in   1      writeback enable
//   testRegAddress  in   RAW    debug read index
//   testRegData     out  DW     stored value of testRegAddress (never bypassed)
//   ctrlD           out  ctrl_t RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch,
//                               ALUControl[3:0], ALUSrc, JALRInstr, AddressingControl[2:0]
//   RD1D, RD2D      out  DW     register operands
//   Rs1D, Rs2D, RdD out  RAW    instr[19:15], [24:20], [11:7]
//   ExtImmD         out  DW     sign-extended immediate (I/S/B/U/J per ImmSrc)
//   PCD, PCPlus4D   out  DW     latched PC / PC+4
//   ValidD          out  1      IF/ID holds a real instruction
//   IllegalD        out  1      ValidD && opcode unsupported
//   IllegalSeen     out  1      sticky: any IllegalD since reset
//   DecodeCount     out  CNTW   instructions handed from D to E
// BEHAVIOUR
//   - Reset: instr=32'h0000_0013 (NOP), PC/PCPlus4=0, ValidD=0, IllegalSeen=0,
//     DecodeCount=0, all registers x0..x(N-1)=0. rst overrides stall/flush/write same edge.
//   - IF/ID priority per edge: rst > FlushD (load NOP, ValidD=0) > StallD (hold) > load
//     instrF/PCF/PCPlus4F, ValidD=1. Latency F->D one cycle.
//   - Decode combinational from IF/ID; RegWrite/MemWrite/Jump/Branch forced 0 when
//     !ValidD or IllegalD. Other ctrl fields follow the opcode unchanged.
//   - Supported opcodes: 0000011,0010011,0010111,0100011,0110011,0110111,1100011,
//     1100111,1101111; anything else is illegal.
//   - Register file: write on posedge when RegWriteW && RdW!=0; x0 reads 0 always;
//     two async read ports + test port.
//   - IllegalSeen set on edge after IllegalD=1; cleared only by rst.
//   - DecodeCount += 1 on edge where ValidD && !StallD && !rst; saturates at all-ones
//     (no wrap). Flush in same cycle still counts the instruction leaving D.
// CONFIGURATION
//   DECODE_WB_BYPASS_EN defined: RDn = ResultW when RegWriteW && RdW==Rsn && Rsn!=0
//     (same-cycle write visible to decode; hazard unit need not stall for W->D).
//   Undefined: RDn = stored value; same-cycle write visible next cycle only.
// STRUCTURE
//   decode_pkg: ctrl_t struct, opcode localparams, ImmSrc enum, NOP constant.
//   Sub-module regfile_bypass (storage, reset, x0 rule, bypass); decode/extend
//   logic and IF/ID register inline.
// TESTING
//   1 rst high 2 cycles with instrF=addi x1,x0,5 -> ValidD=0, ctrlD.RegWrite=0, count=0.
//   2 instrF=0x00500093, no stall -> next cycle RdD=1, ExtImmD=5, RegWrite=1, ALUSrc=1.
//   3 StallD=1 3 cycles, instrF changes -> instr/PCD held, DecodeCount unchanged;
//     StallD=FlushD=1 -> NOP loaded, ValidD=0.
//   4 RegWriteW=1, RdW=3, ResultW=0xDEAD_BEEF, decode Rs1=3 same cycle -> RD1D=DEADBEEF
//     with _EN, old value without; RdW=0 write -> x0 stays 0.
//   5 instrF=0x0000_007F -> IllegalD=1, RegWrite/MemWrite=0, IllegalSeen=1 next edge,
//     stays 1 after legal instrs until rst.
//   6 CNT_WIDTH=4, 20 valid unstalled instrs -> DecodeCount=15, holds; rst -> 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage: control bundle,
// opcode/ALU encodings, immediate-format selector and the NOP instruction.
package decode_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [3:0] ALUControl;
        logic       ALUSrc;
        logic       JALRInstr;
        logic [2:0] AddressingControl;
    } ctrl_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    localparam logic [1:0] RES_ALU   = 2'd0;
    localparam logic [1:0] RES_MEM   = 2'd1;
    localparam logic [1:0] RES_PC4   = 2'd2;
    localparam logic [1:0] RES_PCIMM = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // funct7[5] selects SUB only for register-register ops; for immediates it only picks SRA.
    function automatic logic [3:0] alu_decode(input logic [2:0] funct3,
                                              input logic       f7b5,
                                              input logic       is_reg);
        case (funct3)
            3'b000:  alu_decode = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            default: alu_decode = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Register file with synchronous reset, hard-wired x0 and two async read ports plus a
// debug port. Macro DECODE_WB_BYPASS_EN forwards a same-cycle write to the operand ports.
module regfile_bypass #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_wa,
    input  logic [DATA_WIDTH-1:0] i_wd,
    input  logic [ADDR_WIDTH-1:0] i_ra1,
    input  logic [ADDR_WIDTH-1:0] i_ra2,
    input  logic [ADDR_WIDTH-1:0] i_rat,
    output logic [DATA_WIDTH-1:0] o_rd1,
    output logic [DATA_WIDTH-1:0] o_rd2,
    output logic [DATA_WIDTH-1:0] o_rdt
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_stored1;
    logic [DATA_WIDTH-1:0] w_stored2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else if (i_we && (i_wa != '0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign w_stored1 = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
    assign w_stored2 = (i_ra2 == '0) ? '0 : r_regs[i_ra2];
    assign o_rdt     = (i_rat == '0) ? '0 : r_regs[i_rat];

`ifdef DECODE_WB_BYPASS_EN
    assign o_rd1 = (i_we && (i_wa == i_ra1) && (i_ra1 != '0)) ? i_wd : w_stored1;
    assign o_rd2 = (i_we && (i_wa == i_ra2) && (i_ra2 != '0)) ? i_wd : w_stored2;
`else
    assign o_rd1 = w_stored1;
    assign o_rd2 = w_stored2;
`endif

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, register file, control/immediate decode, illegal-opcode
// flag and saturating decode counter. Optional W->D bypass via DECODE_WB_BYPASS_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH             = 32,
    parameter int REG_FILE_ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH              = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              StallD,
    input  logic                              FlushD,
    input  logic [DATA_WIDTH-1:0]             instrF,
    input  logic [DATA_WIDTH-1:0]             PCF,
    input  logic [DATA_WIDTH-1:0]             PCPlus4F,
    input  logic [DATA_WIDTH-1:0]             ResultW,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW,
    input  logic                              RegWriteW,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] testRegAddress,
    output logic [DATA_WIDTH-1:0]             testRegData,
    output ctrl_t                             ctrlD,
    output logic [DATA_WIDTH-1:0]             RD1D,
    output logic [DATA_WIDTH-1:0]             RD2D,
    output logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1D,
    output logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2D,
    output logic [REG_FILE_ADDRESS_WIDTH-1:0] RdD,
    output logic [DATA_WIDTH-1:0]             ExtImmD,
    output logic [DATA_WIDTH-1:0]             PCD,
    output logic [DATA_WIDTH-1:0]             PCPlus4D,
    output logic                              ValidD,
    output logic                              IllegalD,
    output logic                              IllegalSeen,
    output logic [CNT_WIDTH-1:0]              DecodeCount
);
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_pc4;
    logic                  r_valid;
    logic                  r_illegal_seen;
    logic [CNT_WIDTH-1:0]  r_count;

    logic [31:0]           w_instr;
    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic                  w_f7b5;
    logic                  w_supported;
    logic                  w_illegal;
    imm_src_t              w_imm_src;
    ctrl_t                 w_ctrl;
    logic [31:0]           w_imm32;

    // IF/ID register: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (rst || FlushD) begin
            r_instr <= DATA_WIDTH'(NOP_INSTR);
            r_pc    <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (!StallD) begin
            r_instr <= instrF;
            r_pc    <= PCF;
            r_pc4   <= PCPlus4F;
            r_valid <= 1'b1;
        end
    end

    assign w_instr  = r_instr[31:0];
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];
    assign w_f7b5   = w_instr[30];

    always_comb begin
        w_ctrl      = '0;
        w_imm_src   = IMM_I;
        w_supported = 1'b1;
        case (w_opcode)
            OP_LOAD: begin
                w_ctrl.RegWrite          = 1'b1;
                w_ctrl.ResultSrc         = RES_MEM;
                w_ctrl.ALUSrc            = 1'b1;
                w_ctrl.AddressingControl = w_funct3;
            end
            OP_OPIMM: begin
                w_ctrl.RegWrite   = 1'b1;
                w_ctrl.ALUSrc     = 1'b1;
                w_ctrl.ALUControl = alu_decode(w_funct3, w_f7b5, 1'b0);
            end
            OP_AUIPC: begin
                w_ctrl.RegWrite  = 1'b1;
                w_ctrl.ResultSrc = RES_PCIMM;
                w_ctrl.ALUSrc    = 1'b1;
                w_imm_src        = IMM_U;
            end
            OP_STORE: begin
                w_ctrl.MemWrite          = 1'b1;
                w_ctrl.ALUSrc            = 1'b1;
                w_ctrl.AddressingControl = w_funct3;
                w_imm_src                = IMM_S;
            end
            OP_REG: begin
                w_ctrl.RegWrite   = 1'b1;
                w_ctrl.ALUControl = alu_decode(w_funct3, w_f7b5, 1'b1);
            end
            OP_LUI: begin
                w_ctrl.RegWrite   = 1'b1;
                w_ctrl.ALUSrc     = 1'b1;
                w_ctrl.ALUControl = ALU_LUI;
                w_imm_src         = IMM_U;
            end
            OP_BRANCH: begin
                w_ctrl.Branch            = 1'b1;
                w_ctrl.ALUControl        = ALU_SUB;
                w_ctrl.AddressingControl = w_funct3;
                w_imm_src                = IMM_B;
            end
            OP_JALR: begin
                w_ctrl.RegWrite  = 1'b1;
                w_ctrl.ResultSrc = RES_PC4;
                w_ctrl.Jump      = 1'b1;
                w_ctrl.ALUSrc    = 1'b1;
                w_ctrl.JALRInstr = 1'b1;
            end
            OP_JAL: begin
                w_ctrl.RegWrite  = 1'b1;
                w_ctrl.ResultSrc = RES_PC4;
                w_ctrl.Jump      = 1'b1;
                w_imm_src        = IMM_J;
            end
            default: w_supported = 1'b0;
        endcase

        w_illegal = r_valid && !w_supported;
        // Bubbles and illegal instructions must not change architectural state.
        if (!r_valid || w_illegal) begin
            w_ctrl.RegWrite = 1'b0;
            w_ctrl.MemWrite = 1'b0;
            w_ctrl.Jump     = 1'b0;
            w_ctrl.Branch   = 1'b0;
        end
    end

    always_comb begin
        case (w_imm_src)
            IMM_S:   w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            IMM_B:   w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                                w_instr[30:25], w_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {w_instr[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                                w_instr[20], w_instr[30:21], 1'b0};
            default: w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_seen <= 1'b0;
            r_count        <= '0;
        end else begin
            if (w_illegal) r_illegal_seen <= 1'b1;
            // Flush does not gate the count: the instruction still leaves D this edge.
            if (r_valid && !StallD && (r_count != {CNT_WIDTH{1'b1}})) r_count <= r_count + 1'b1;
        end
    end

    regfile_bypass #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(REG_FILE_ADDRESS_WIDTH)
    ) u_regfile (
        .i_clk(clk),
        .i_rst(rst),
        .i_we (RegWriteW),
        .i_wa (RdW),
        .i_wd (ResultW),
        .i_ra1(Rs1D),
        .i_ra2(Rs2D),
        .i_rat(testRegAddress),
        .o_rd1(RD1D),
        .o_rd2(RD2D),
        .o_rdt(testRegData)
    );

    assign Rs1D        = w_instr[15 +: REG_FILE_ADDRESS_WIDTH];
    assign Rs2D        = w_instr[20 +: REG_FILE_ADDRESS_WIDTH];
    assign RdD         = w_instr[7  +: REG_FILE_ADDRESS_WIDTH];
    assign ctrlD       = w_ctrl;
    assign ExtImmD     = DATA_WIDTH'($signed(w_imm32));
    assign PCD         = r_pc;
    assign PCPlus4D    = r_pc4;
    assign ValidD      = r_valid;
    assign IllegalD    = w_illegal;
    assign IllegalSeen = r_illegal_seen;
    assign DecodeCount = r_count;

endmodule
